// File: rtl/controller_interface_if.sv
// CPU-side read bus for the controller block.
// The address decoder and CPU own select/address_lsb (master).
// The controller block drives data_out back onto the shared data bus (slave).
interface controller_interface_if;
    logic       select;
    logic       address_lsb;
    logic [7:0] data_out;

    modport master (
        output select,
        output address_lsb,
        input  data_out
    );

    modport slave (
        input  select,
        input  address_lsb,
        output data_out
    );
endinterface

// File: rtl/controller_interface.sv
// Polls two NES-style serial game controllers once per frame.
// Each poll latches both pads, then shifts in 8 bits MSB first (A..Right).
// The results are committed to CPU-readable button bytes, where 1 = pressed.
// Optional macro CONTROLLER_DEBOUNCE_EN:
//   a committed bit changes only when two consecutive polls agree on it.
module controller_interface #(
    parameter int unsigned CLK_DIV = 76
) (
    input  logic                   clk_12_5875,
    input  logic                   rst_B,
    input  logic                   poll_start,
    controller_interface_if.slave  cpu,
    output logic                   ctrl_latch,
    output logic                   ctrl_clk,
    input  logic                   ctrl_data_1_B,
    input  logic                   ctrl_data_2_B,
    output logic                   busy
);

    localparam int unsigned TickW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSample,
        StPulse,
        StCommit
    } state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sr1_q, sr1_d;
    logic [7:0]       sr2_q, sr2_d;
    logic [7:0]       com1_q, com1_d;
    logic [7:0]       com2_q, com2_d;
    logic [1:0]       sync1_q, sync2_q;
    logic             ctrl_latch_q, ctrl_latch_d;
    logic             ctrl_clk_q, ctrl_clk_d;
    logic             busy_q, busy_d;
    logic             tick_end;
    logic             pressed1, pressed2;

`ifdef CONTROLLER_DEBOUNCE_EN
    logic [7:0]       prev1_q, prev1_d;
    logic [7:0]       prev2_q, prev2_d;
`endif

    assign tick_end = (tick_q == TickLast);
    // Pad lines idle high, so the synchronizers reset to "released"
    assign pressed1 = ~sync1_q[1];
    assign pressed2 = ~sync2_q[1];

    // Two-flop synchronizers for the asynchronous pad data lines
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {sync1_q[0], ctrl_data_1_B};
            sync2_q <= {sync2_q[0], ctrl_data_2_B};
        end
    end

    // Poll sequencer: next state, counters, shift and commit registers
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sr1_d   = sr1_q;
        sr2_d   = sr2_q;
        com1_d  = com1_q;
        com2_d  = com2_q;
`ifdef CONTROLLER_DEBOUNCE_EN
        prev1_d = prev1_q;
        prev2_d = prev2_q;
`endif

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                bit_d  = '0;
                if (poll_start) begin
                    state_d = StLatch;
                end
            end

            // Latch lasts two ticks; bit_q[0] marks the second tick
            StLatch: begin
                if (tick_end) begin
                    tick_d = '0;
                    if (bit_q[0]) begin
                        bit_d   = '0;
                        state_d = StSample;
                    end else begin
                        bit_d = 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StSample: begin
                if (tick_end) begin
                    tick_d = '0;
                    sr1_d  = {sr1_q[6:0], pressed1};
                    sr2_d  = {sr2_q[6:0], pressed2};
                    if (bit_q == 3'd7) begin
                        state_d = StCommit;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = StPulse;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StPulse: begin
                if (tick_end) begin
                    tick_d  = '0;
                    state_d = StSample;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StCommit: begin
`ifdef CONTROLLER_DEBOUNCE_EN
                // Only bits that match the previous poll's raw sample may change
                for (int i = 0; i < 8; i++) begin
                    if (sr1_q[i] == prev1_q[i]) begin
                        com1_d[i] = sr1_q[i];
                    end
                    if (sr2_q[i] == prev2_q[i]) begin
                        com2_d[i] = sr2_q[i];
                    end
                end
                prev1_d = sr1_q;
                prev2_d = sr2_q;
`else
                com1_d = sr1_q;
                com2_d = sr2_q;
`endif
                tick_d  = '0;
                bit_d   = '0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered off the next state so they align with state_q
        ctrl_latch_d = (state_d == StLatch);
        ctrl_clk_d   = (state_d == StPulse);
        busy_d       = (state_d != StIdle);
    end

    // State, counter and data registers; reset aborts any poll in flight
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            bit_q        <= '0;
            sr1_q        <= 8'h00;
            sr2_q        <= 8'h00;
            com1_q       <= 8'h00;
            com2_q       <= 8'h00;
            ctrl_latch_q <= 1'b0;
            ctrl_clk_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            sr1_q        <= sr1_d;
            sr2_q        <= sr2_d;
            com1_q       <= com1_d;
            com2_q       <= com2_d;
            ctrl_latch_q <= ctrl_latch_d;
            ctrl_clk_q   <= ctrl_clk_d;
            busy_q       <= busy_d;
        end
    end

`ifdef CONTROLLER_DEBOUNCE_EN
    // Previous raw samples used by the debounce comparison
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            prev1_q <= 8'h00;
            prev2_q <= 8'h00;
        end else begin
            prev1_q <= prev1_d;
            prev2_q <= prev2_d;
        end
    end
`endif

    assign ctrl_latch = ctrl_latch_q;
    assign ctrl_clk   = ctrl_clk_q;
    assign busy       = busy_q;

    // CPU read mux; the bus is driven low when the block is not selected
    always_comb begin
        cpu.data_out = 8'h00;
        if (cpu.select) begin
            cpu.data_out = cpu.address_lsb ? com2_q : com1_q;
        end
    end

endmodule

// File: doc/controller_interface.md
Name: controller_interface

Overview:
- Polls the two NES-style serial game controllers once per frame and presents each button byte to the CPU bus.
- Sits downstream of the top-level address decoder and consumes the SELECT_controller strobe plus address bit 0.
- Drives data_out onto the shared CPU data bus on reads.
- The poll is triggered by the GPU's vblank start, so the button state is stable for the whole game-logic window.

Parameters:
- CLK_DIV, 76, clk_12_5875 cycles per protocol tick (≈6.04 µs); must be ≥2.

Ports:
- clk_12_5875  input  1  GPU pixel clock, sole clock
- rst_B  input  1  asynchronous active-low reset
- poll_start  input  1  one-cycle pulse at vblank start; begins a poll
- select  input  1  SELECT_controller from address decode
- address_lsb  input  1  cpu_address[0]: 0 = controller 1 ($7000), 1 = controller 2 ($7001)
- data_out  output  8  committed button byte for the selected controller; 1 = pressed
- ctrl_latch  output  1  latch line to both controllers
- ctrl_clk  output  1  shift clock to both controllers
- ctrl_data_1_B  input  1  serial data, controller 1, active-low, asynchronous
- ctrl_data_2_B  input  1  serial data, controller 2, active-low, asynchronous
- busy  output  1  high while a poll is in progress

Behaviour:
- Reset (async, rst_B=0):
  - state IDLE; ctrl_latch=0, ctrl_clk=0, busy=0.
  - Both committed registers and both shift registers = 0x00; tick counter and bit counter = 0.
  - data_out = 0x00.
- Reset mid-poll: abort immediately, return to reset values, and discard the partial shift data.
- Synchronization: ctrl_data_*_B pass through a 2-flop synchronizer and are inverted, so pressed = 1.
- Tick counter: counts 0..CLK_DIV-1 while busy. A tick ends on the cycle the count equals CLK_DIV-1.
- FSM:
  - IDLE:
    - poll_start=1 -> LATCH; counters cleared.
    - busy=1 from the next cycle.
  - LATCH:
    - ctrl_latch=1 for exactly 2*CLK_DIV cycles, then -> SAMPLE.
  - SAMPLE:
    - ctrl_latch=0, ctrl_clk=0 for CLK_DIV cycles.
    - On the last cycle, shift the synchronized bit of each controller into its shift register, MSB first (first serial bit = A -> bit 7; order A,B,Select,Start,Up,Down,Left,Right).
    - If bit counter=7 -> COMMIT; else increment the bit counter -> PULSE.
  - PULSE:
    - ctrl_clk=1 for CLK_DIV cycles, then -> SAMPLE.
  - COMMIT:
    - One cycle: copy both shift registers into the committed registers, then -> IDLE.
    - busy falls the cycle after COMMIT.
- Poll duration from the poll_start edge to busy low: (2+8+7)*CLK_DIV + 2 cycles.
  - Exactly 8 SAMPLE phases and 7 ctrl_clk pulses per poll.
- poll_start while busy (any non-IDLE state): ignored; no queuing.
- CPU read path:
  - data_out is combinational from the committed registers: address_lsb ? ctrl2 : ctrl1.
  - When select=0, data_out=0x00.
  - Committed registers change only in COMMIT, so a read never sees a partially shifted byte.
  - A read coincident with COMMIT returns the old value in that cycle and the new value from the next cycle.
- The block never accepts CPU writes.
- All outputs are registered except data_out.

Optional Feature:
- Macro: CONTROLLER_DEBOUNCE_EN.
- Defined:
  - COMMIT updates each committed bit only when the new sample equals the previous poll's raw sample for that bit.
  - This requires an extra 8-bit previous-raw register per controller, reset to 0x00.
  - A single-poll glitch is never visible; a press becomes visible at the end of the second consecutive poll that sees it.
- Undefined: COMMIT copies the raw shift registers directly, as described in Behaviour.

Test Plan (CLK_DIV=4 unless noted):
- Reset, then hold rst_B=0 -> ctrl_latch=0, ctrl_clk=0, busy=0; select=1 with address_lsb 0 and 1 each -> data_out=0x00.
- Controller models hold raw serial 0b01111110 (ctrl1) and 0b11111111 (ctrl2), then poll_start pulse:
  - ctrl_latch high exactly 8 cycles; exactly 7 ctrl_clk pulses of 4 cycles each.
  - busy low 70 cycles after the pulse.
  - Read $7000 -> 0x81; read $7001 -> 0x00.
- poll_start re-pulsed at cycles 10 and 40 of an active poll -> no restart; latch/clock timing identical to a single poll; exactly one COMMIT.
- rst_B asserted during PULSE of bit 3, then released and polled with ctrl1 raw 0x00 -> immediately 0x00 after reset; after the new poll, read $7000 -> 0xFF.
- Read $7000 continuously across COMMIT with the old value 0x81 and new value 0x42 -> 0x81 through the COMMIT cycle, 0x42 the cycle after; never any other value.
- With CONTROLLER_DEBOUNCE_EN, ctrl1 pressing A (bit 7) on poll 1 only -> $7000 stays 0x00; A held on polls 2 and 3 -> 0x00 after poll 2, 0x80 after poll 3.
